// File: rtl/combination_lock_supervisor.sv
// Dial-sequence combination lock supervisor: three-number code check, failed-attempt lockout, code reprogramming.
// Build option LOCK_AUTO_RELOCK_EN: an idle OPEN lock relocks after RELOCK_CYCLES cycles.
module combination_lock_supervisor #(
   parameter int DIAL_MAX       = 19,
   parameter int CODE0          = 13,
   parameter int CODE1          = 7,
   parameter int CODE2          = 17,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int TIMER_W        = 16
`ifdef LOCK_AUTO_RELOCK_EN
   ,
   parameter int RELOCK_CYCLES  = 500
`endif
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Right,
   input  logic       Left,
   input  logic [4:0] Count,
   input  logic       Center,
   input  logic       ProgEn,
   output logic       Locked,
   output logic       LockedOut,
   output logic [2:0] FailCount,
   output logic [2:0] State
);

   typedef enum logic [2:0] {
      ST_S0      = 3'd0,
      ST_S1      = 3'd1,
      ST_S2      = 3'd2,
      ST_OPEN    = 3'd3,
      ST_PROG    = 3'd4,
      ST_LOCKOUT = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_R    = 2'd1,
      DIR_L    = 2'd2
   } dir_t;

   localparam logic [4:0]         DIAL_MAX_C   = 5'(DIAL_MAX);
   localparam logic [2:0]         MAX_FAILS_C  = 3'(MAX_FAILS);
   localparam logic [TIMER_W-1:0] TIMER_ZERO   = {TIMER_W{1'b0}};
   localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
   localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
`ifdef LOCK_AUTO_RELOCK_EN
   localparam logic [TIMER_W-1:0] RELOCK_LOAD  = TIMER_W'(RELOCK_CYCLES - 1);
`endif

   state_t             state_r;
   dir_t               dir_r;
   logic [2:0]         fails_r;
   logic [4:0]         code0_r;
   logic [4:0]         code1_r;
   logic [4:0]         code2_r;
   logic [1:0]         slot_r;
   logic [TIMER_W-1:0] timer_r;

   logic r_only_s;
   logic l_only_s;
   logic rev_rl_s;
   logic rev_lr_s;
   logic count_ok_s;
   logic fail_s;

   // Positions beyond the dial range can never match, whatever the code register holds.
   function automatic logic code_match(input logic [4:0] pos, input logic [4:0] code);
      return (pos <= DIAL_MAX_C) && (pos == code);
   endfunction

   // Both direction lines high is treated as no movement.
   assign r_only_s   = Right & ~Left;
   assign l_only_s   = Left & ~Right;
   assign rev_rl_s   = l_only_s & (dir_r == DIR_R);
   assign rev_lr_s   = r_only_s & (dir_r == DIR_L);
   assign count_ok_s = (Count <= DIAL_MAX_C);

   // Failed-attempt detection for the three entry states.
   always_comb begin
      fail_s = 1'b0;
      case (state_r)
         ST_S0: begin
            if (Center) fail_s = 1'b1;
            else if (rev_rl_s) fail_s = ~code_match(Count, code0_r);
            else fail_s = 1'b0;
         end
         ST_S1: begin
            if (Center) fail_s = 1'b1;
            else if (rev_lr_s) fail_s = ~code_match(Count, code1_r);
            else fail_s = 1'b0;
         end
         ST_S2: begin
            if (l_only_s) fail_s = 1'b1;
            else if (Center) fail_s = ~code_match(Count, code2_r);
            else fail_s = 1'b0;
         end
         default: fail_s = 1'b0;
      endcase
   end

   // Supervisor state machine, direction tracking, code storage and shared lockout/relock timer.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_r <= ST_S0;
         dir_r   <= DIR_NONE;
         fails_r <= 3'd0;
         code0_r <= 5'(CODE0);
         code1_r <= 5'(CODE1);
         code2_r <= 5'(CODE2);
         slot_r  <= 2'd0;
         timer_r <= TIMER_ZERO;
      end else begin
         if (state_r != ST_LOCKOUT) begin
            if (r_only_s) dir_r <= DIR_R;
            else if (l_only_s) dir_r <= DIR_L;
         end
         if (fail_s) begin
            dir_r   <= DIR_NONE;
            fails_r <= fails_r + 3'd1;
            if ((fails_r + 3'd1) == MAX_FAILS_C) begin
               state_r <= ST_LOCKOUT;
               timer_r <= LOCKOUT_LOAD;
            end else begin
               state_r <= ST_S0;
            end
         end else begin
            case (state_r)
               ST_S0:   if (rev_rl_s) state_r <= ST_S1;
               ST_S1:   if (rev_lr_s) state_r <= ST_S2;
               ST_S2: begin
                  if (Center) begin
                     state_r <= ST_OPEN;
                     fails_r <= 3'd0;
`ifdef LOCK_AUTO_RELOCK_EN
                     timer_r <= RELOCK_LOAD;
`endif
                  end
               end
               ST_OPEN: begin
                  if (Center) begin
                     if (ProgEn) begin
                        state_r <= ST_PROG;
                        slot_r  <= 2'd0;
                     end else begin
                        state_r <= ST_S0;
                        dir_r   <= DIR_NONE;
                     end
                  end
`ifdef LOCK_AUTO_RELOCK_EN
                  else if (Right || Left) timer_r <= RELOCK_LOAD;
                  else if (timer_r == TIMER_ZERO) begin
                     state_r <= ST_S0;
                     dir_r   <= DIR_NONE;
                  end
                  else timer_r <= timer_r - TIMER_ONE;
`else
                  else state_r <= ST_OPEN;
`endif
               end
               ST_PROG: begin
                  if (Center && count_ok_s) begin
                     case (slot_r)
                        2'd0: begin
                           code0_r <= Count;
                           slot_r  <= 2'd1;
                        end
                        2'd1: begin
                           code1_r <= Count;
                           slot_r  <= 2'd2;
                        end
                        default: begin
                           code2_r <= Count;
                           slot_r  <= 2'd0;
                           state_r <= ST_OPEN;
`ifdef LOCK_AUTO_RELOCK_EN
                           timer_r <= RELOCK_LOAD;
`endif
                        end
                     endcase
                  end
               end
               ST_LOCKOUT: begin
                  if (timer_r == TIMER_ZERO) begin
                     state_r <= ST_S0;
                     fails_r <= 3'd0;
                     dir_r   <= DIR_NONE;
                  end else begin
                     timer_r <= timer_r - TIMER_ONE;
                  end
               end
               default: begin
                  state_r <= ST_S0;
                  dir_r   <= DIR_NONE;
               end
            endcase
         end
      end
   end

   assign Locked    = (state_r != ST_OPEN) && (state_r != ST_PROG);
   assign LockedOut = (state_r == ST_LOCKOUT);
   assign FailCount = fails_r;
   assign State     = state_r;

endmodule

// File: tb/tb_combination_lock_supervisor.sv
// Scoreboard bench for combination_lock_supervisor: directed sequences plus randomized dialing against a behavioural model.
module tb_combination_lock_supervisor;

   localparam int DIAL_MAX       = 19;
   localparam int MAX_FAILS      = 3;
   localparam int LOCKOUT_CYCLES = 1000;
   localparam int RELOCK_CYCLES  = 500;
   localparam int S0 = 0, S1 = 1, S2 = 2, OPEN = 3, PROG = 4, LOCKOUT = 5;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       Right, Left, Center, ProgEn;
   logic [4:0] Count;
   logic       Locked, LockedOut;
   logic [2:0] FailCount, State;

   combination_lock_supervisor dut (
      .Clk(Clk), .Rst(Rst), .Right(Right), .Left(Left), .Count(Count),
      .Center(Center), .ProgEn(ProgEn), .Locked(Locked), .LockedOut(LockedOut),
      .FailCount(FailCount), .State(State)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [2:0] st;
      logic       lk;
      logic       lo;
      logic [2:0] fc;
   } obs_t;

   obs_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   bit   started  = 1'b0;
   bit   done     = 1'b0;

   // Reference model: mode, last direction (+1 right, -1 left, 0 none), codes, failures, timer.
   int m_state, m_last, m_fails, m_timer, m_slot;
   int m_code[3];

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endfunction

   function automatic void model_reset();
      m_state = S0; m_last = 0; m_fails = 0; m_timer = 0; m_slot = 0;
      m_code[0] = 13; m_code[1] = 7; m_code[2] = 17;
   endfunction

   function automatic bit hit(int cnt, int idx);
      return (cnt <= DIAL_MAX) && (cnt == m_code[idx]);
   endfunction

   function automatic void push_expect();
      obs_t e;
      e.st = 3'(m_state);
      e.lk = !(m_state == OPEN || m_state == PROG);
      e.lo = (m_state == LOCKOUT);
      e.fc = 3'(m_fails);
      sb.push_back(e);
      started = 1'b1;
   endfunction

   function automatic void model_step(bit r, bit l, int cnt, bit c, bit pe);
      int dir;
      bit rev, fail;
      dir  = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
      rev  = (dir != 0) && (m_last != 0) && (dir != m_last);
      fail = 1'b0;
      if (m_state == LOCKOUT) begin
         if (m_timer == 0) begin
            m_state = S0; m_fails = 0; m_last = 0;
         end else m_timer--;
      end else begin
         if (dir != 0) m_last = dir;
         case (m_state)
            S0: if (c) fail = 1'b1;
                else if (rev && dir == -1) begin
                   if (hit(cnt, 0)) m_state = S1; else fail = 1'b1;
                end
            S1: if (c) fail = 1'b1;
                else if (rev && dir == 1) begin
                   if (hit(cnt, 1)) m_state = S2; else fail = 1'b1;
                end
            S2: if (dir == -1) fail = 1'b1;
                else if (c) begin
                   if (hit(cnt, 2)) begin
                      m_state = OPEN; m_fails = 0; m_timer = RELOCK_CYCLES - 1;
                   end else fail = 1'b1;
                end
            OPEN: begin
               if (c) begin
                  if (pe) begin m_state = PROG; m_slot = 0; end
                  else begin m_state = S0; m_last = 0; end
               end
`ifdef LOCK_AUTO_RELOCK_EN
               else if (r || l) m_timer = RELOCK_CYCLES - 1;
               else if (m_timer == 0) begin m_state = S0; m_last = 0; end
               else m_timer--;
`endif
            end
            PROG: if (c && cnt <= DIAL_MAX) begin
               m_code[m_slot] = cnt;
               m_slot++;
               if (m_slot == 3) begin
                  m_slot = 0; m_state = OPEN; m_timer = RELOCK_CYCLES - 1;
               end
            end
            default: m_state = S0;
         endcase
         if (fail) begin
            m_last = 0;
            m_fails++;
            if (m_fails == MAX_FAILS) begin
               m_state = LOCKOUT; m_timer = LOCKOUT_CYCLES - 1;
            end else m_state = S0;
         end
      end
   endfunction

   // Called at a falling edge: drive one cycle of inputs, predict the post-edge outputs.
   task automatic step(input bit r, input bit l, input int cnt, input bit c, input bit pe);
      Right = r; Left = l; Count = 5'(cnt); Center = c; ProgEn = pe;
      model_step(r, l, cnt, c, pe);
      push_expect();
      @(negedge Clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic dial_code(input int a, input int b, input int c);
      step(1'b1, 1'b0, a, 1'b0, 1'b0);
      step(1'b0, 1'b1, a, 1'b0, 1'b0);
      step(1'b0, 1'b1, (b + 3) % 32, 1'b0, 1'b0);
      step(1'b1, 1'b0, b, 1'b0, 1'b0);
      step(1'b1, 1'b0, c, 1'b0, 1'b0);
      step(1'b0, 1'b0, c, 1'b1, 1'b0);
   endtask

   task automatic settle();
      for (int i = 0; i < 2000 && m_state != S0; i++) begin
         if (m_state == LOCKOUT) step(1'b0, 1'b0, 0, 1'b0, 1'b0);
         else if (m_state == PROG) step(1'b0, 1'b0, $urandom_range(0, DIAL_MAX), 1'b1, 1'b0);
         else step(1'b0, 1'b0, 0, 1'b1, 1'b0);
      end
   endtask

   task automatic async_reset();
      #2;
      Rst = 1'b0; Right = 1'b0; Left = 1'b0; Center = 1'b0; ProgEn = 1'b0; Count = 5'd0;
      #1;
      chk("async_rst_state", int'(State), S0);
      chk("async_rst_locked", int'(Locked), 1);
      chk("async_rst_lockedout", int'(LockedOut), 0);
      chk("async_rst_failcount", int'(FailCount), 0);
      model_reset();
      push_expect();
      @(negedge Clk);
      Rst = 1'b1;
   endtask

   function automatic int pick(int idx);
      return ($urandom_range(0, 3) != 0) ? m_code[idx] : int'($urandom_range(0, 31));
   endfunction

   // Monitor: every cycle the DUT presents its outputs; compare against the oldest prediction.
   initial begin
      obs_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({State, Locked, LockedOut, FailCount} !== e) begin
               failures++;
               $display("FAIL scoreboard t=%0t actual st=%0d lk=%0b lo=%0b fc=%0d required st=%0d lk=%0b lo=%0b fc=%0d",
                        $time, State, Locked, LockedOut, FailCount, e.st, e.lk, e.lo, e.fc);
            end
         end else if (started && !done) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_underflow t=%0t actual=empty required=entry", $time);
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst = 1'b0; Right = 1'b0; Left = 1'b0; Center = 1'b0; ProgEn = 1'b0; Count = 5'd0;
      model_reset();
      repeat (2) @(negedge Clk);
      chk("reset_state", int'(State), S0);
      chk("reset_locked", int'(Locked), 1);
      chk("reset_lockedout", int'(LockedOut), 0);
      chk("reset_failcount", int'(FailCount), 0);
      Rst = 1'b1;

      // Default code opens, then relock with Center.
      dial_code(13, 7, 17);
      step(1'b0, 1'b0, 0, 1'b1, 1'b0);

      // Three wrong first numbers lead to lockout; inputs during lockout are ignored.
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, 12, 1'b0, 1'b0);
         step(1'b0, 1'b1, 12, 1'b0, 1'b0);
      end
      for (int i = 0; i < LOCKOUT_CYCLES + 5; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 31),
              ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      settle();

      // Both direction lines high in S1 neither moves nor reverses.
      step(1'b1, 1'b0, 13, 1'b0, 1'b0);
      step(1'b0, 1'b1, 13, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 7, 1'b0, 1'b0);
      step(1'b0, 1'b0, 7, 1'b1, 1'b0);
      step(1'b1, 1'b0, 13, 1'b0, 1'b0);
      step(1'b0, 1'b1, 13, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3, 1'b0, 1'b0);
      step(1'b1, 1'b0, 7, 1'b0, 1'b0);
      step(1'b0, 1'b1, 9, 1'b0, 1'b0);
      settle();

      // Program 3/9/1 (25 is out of range), then check new and old codes.
      dial_code(13, 7, 17);
      step(1'b0, 1'b0, 0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 3, 1'b1, 1'b1);
      step(1'b0, 1'b0, 25, 1'b1, 1'b1);
      step(1'b0, 1'b0, 9, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 0, 1'b1, 1'b0);
      dial_code(3, 9, 1);
      step(1'b0, 1'b0, 0, 1'b1, 1'b0);
      dial_code(13, 7, 17);
      settle();

      // Reset mid-programming restores the default code.
      dial_code(3, 9, 1);
      step(1'b0, 1'b0, 0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 5, 1'b1, 1'b1);
      async_reset();
      dial_code(13, 7, 17);
      step(1'b0, 1'b0, 0, 1'b1, 1'b0);

`ifdef LOCK_AUTO_RELOCK_EN
      dial_code(13, 7, 17);
      idle(RELOCK_CYCLES + 20);
      dial_code(13, 7, 17);
      idle(399);
      step(1'b1, 1'b0, 0, 1'b0, 1'b0);
      idle(RELOCK_CYCLES + 20);
`endif

      // Randomized attempts with occasional reprogramming and noise.
      for (int a = 0; a < 30; a++) begin
         settle();
         dial_code(pick(0), pick(1), pick(2));
         if (m_state == OPEN && $urandom_range(0, 2) == 0) begin
            step(1'b0, 1'b0, 0, 1'b1, 1'b1);
            for (int i = 0; i < 4; i++)
               step(1'b0, 1'b0, $urandom_range(0, 31), 1'b1, 1'($urandom_range(0, 1)));
         end
         for (int i = 0; i < 20; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 31),
                 ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      end

      done = 1'b1;
      @(posedge Clk);
      #2;
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
